// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: reads one WIDTH x HEIGHT frame from a synchronous-read RAM in raster
// order and re-times the returned data into a valid/pixel stream with sof/eol/eof markers.
module frame_pixel_streamer #(
    parameter int BITW    = 8,
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 256,
    parameter int ADDRW   = 16,
    parameter int ROW_GAP = 0
) (
    input  logic             i_CLK,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_hold,
    output logic             o_rd_en,
    output logic [ADDRW-1:0] o_rd_addr,
    input  logic [BITW-1:0]  i_rd_data,
    output logic             o_valid,
    output logic [BITW-1:0]  o_pixel,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      row_count,
    output logic [15:0]      col_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STREAM = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);
    localparam logic [7:0]  GAP_LAST = (ROW_GAP > 0) ? 8'(ROW_GAP - 1) : 8'd0;

    logic [2:0]       state_q, state_d;
    logic [15:0]      col_q, col_d;
    logic [15:0]      row_q, row_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             flush_cnt_q, flush_cnt_d;
    logic             rd_en_q, rd_en_d;
    logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
    logic             sof0_q, sof0_d, eol0_q, eol0_d, eof0_q, eof0_d;
    logic             v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d, eof1_q, eof1_d;
    logic             valid_q, valid_d;
    logic [BITW-1:0]  pixel_q, pixel_d;
    logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      row_count_q, row_count_d;
    logic [15:0]      col_count_q, col_count_d;

    logic             issue;
    logic             pipe_busy;
    logic             last_col;
    logic             last_row;
    logic [15:0]      cur_col;
    logic [15:0]      cur_row;
    logic [ADDRW-1:0] cur_addr;

    // col_q/row_q/addr_q hold the position of the next read to issue; a start issues pixel 0
    // on the same edge so the first read appears the cycle after the start pulse.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        gap_cnt_d   = gap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        sof0_d      = 1'b0;
        eol0_d      = 1'b0;
        eof0_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        row_count_d = row_count_q;
        col_count_d = col_count_q;
        cur_col     = col_q;
        cur_row     = row_q;
        cur_addr    = addr_q;
        issue       = 1'b0;
        pipe_busy   = rd_en_q | v1_q | valid_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_STREAM;
                    busy_d   = 1'b1;
                    cur_col  = '0;
                    cur_row  = '0;
                    cur_addr = '0;
                    col_d    = '0;
                    row_d    = '0;
                    addr_d   = '0;
                    issue    = !i_hold;
                end
            end
            S_STREAM: begin
                issue = !i_hold;
            end
            S_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = S_STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            S_FLUSH: begin
                // Wait for in-flight reads to leave the output, then two quiet cycles.
                if (pipe_busy) begin
                    flush_cnt_d = 1'b0;
                end else if (flush_cnt_q) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    flush_cnt_d = 1'b0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        last_col = (cur_col == COL_LAST);
        last_row = (cur_row == ROW_LAST);

        if (issue) begin
            rd_en_d     = 1'b1;
            rd_addr_d   = cur_addr;
            row_count_d = cur_row;
            col_count_d = cur_col;
            sof0_d      = (cur_col == 16'd0) && (cur_row == 16'd0);
            eol0_d      = last_col;
            eof0_d      = last_col && last_row;
            addr_d      = cur_addr + ADDRW'(1);
            if (last_col) begin
                col_d = 16'd0;
                row_d = cur_row + 16'd1;
                if (last_row) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                end else if (ROW_GAP > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LAST;
                end else begin
                    state_d = S_STREAM;
                end
            end else begin
                col_d = cur_col + 16'd1;
            end
        end
    end

    // Markers travel two stages beside the RAM read so they line up with the returned data.
    always_comb begin
        v1_d    = rd_en_q;
        sof1_d  = sof0_q;
        eol1_d  = eol0_q;
        eof1_d  = eof0_q;
        valid_d = v1_q;
        pixel_d = v1_q ? i_rd_data : '0;
        sof_d   = v1_q & sof1_q;
        eol_d   = v1_q & eol1_q;
        eof_d   = v1_q & eof1_q;
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            gap_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            sof0_q      <= 1'b0;
            eol0_q      <= 1'b0;
            eof0_q      <= 1'b0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            eol1_q      <= 1'b0;
            eof1_q      <= 1'b0;
            valid_q     <= 1'b0;
            pixel_q     <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_count_q <= '0;
            col_count_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            gap_cnt_q   <= gap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            sof0_q      <= sof0_d;
            eol0_q      <= eol0_d;
            eof0_q      <= eof0_d;
            v1_q        <= v1_d;
            sof1_q      <= sof1_d;
            eol1_q      <= eol1_d;
            eof1_q      <= eof1_d;
            valid_q     <= valid_d;
            pixel_q     <= pixel_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            row_count_q <= row_count_d;
            col_count_q <= col_count_d;
        end
    end

    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;
    assign o_valid   = valid_q;
    assign o_pixel   = pixel_q;
    assign o_sof     = sof_q;
    assign o_eol     = eol_q;
    assign o_eof     = eof_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign row_count = row_count_q;
    assign col_count = col_count_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer on a 4x3 frame with RAM[a]=a: cycle tables for issue/valid
// timing, a pixel scoreboard for order and markers, and a ROW_GAP=2 instance alongside.
module tb_frame_pixel_streamer;

    localparam int BITW   = 8;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int ADDRW  = 16;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic             clk = 1'b0;
    logic             rstN;
    logic             start;
    logic             hold;

    logic             rdEn;
    logic [ADDRW-1:0] rdAddr;
    logic [BITW-1:0]  rdData;
    logic             valid;
    logic [BITW-1:0]  pixel;
    logic             sof, eol, eof, busy, done;
    logic [15:0]      rowCnt, colCnt;

    logic             gRdEn;
    logic [ADDRW-1:0] gRdAddr;
    logic [BITW-1:0]  gRdData;
    logic             gValid;
    logic [BITW-1:0]  gPixel;
    logic             gSof, gEol, gEof, gBusy, gDone;
    logic [15:0]      gRowCnt, gColCnt;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } expPix_t;

    typedef struct {
        logic start;
        logic hold;
        logic rdEn;
        int   addr;
        logic valid;
        logic busy;
        logic done;
    } vec_t;

    expPix_t expQ[$];
    expPix_t gapQ[$];
    expPix_t eMain;
    expPix_t eGap;
    vec_t    vecs[19];
    int      gapIssue[$];
    int      gapDoneCyc = -1;
    int      doneCount = 0;
    int      cyc = 0;
    logic    logGap = 1'b0;
    int      total = 0;
    int      bad = 0;

    always #5 clk = ~clk;

    frame_pixel_streamer #(.BITW(BITW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDRW(ADDRW), .ROW_GAP(0)) dut (
        .i_CLK(clk), .i_reset(rstN), .i_start(start), .i_hold(hold),
        .o_rd_en(rdEn), .o_rd_addr(rdAddr), .i_rd_data(rdData),
        .o_valid(valid), .o_pixel(pixel), .o_sof(sof), .o_eol(eol), .o_eof(eof),
        .o_busy(busy), .o_done(done), .row_count(rowCnt), .col_count(colCnt)
    );

    frame_pixel_streamer #(.BITW(BITW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDRW(ADDRW), .ROW_GAP(2)) dutGap (
        .i_CLK(clk), .i_reset(rstN), .i_start(start), .i_hold(1'b0),
        .o_rd_en(gRdEn), .o_rd_addr(gRdAddr), .i_rd_data(gRdData),
        .o_valid(gValid), .o_pixel(gPixel), .o_sof(gSof), .o_eol(gEol), .o_eof(gEof),
        .o_busy(gBusy), .o_done(gDone), .row_count(gRowCnt), .col_count(gColCnt)
    );

    // Synchronous-read image RAMs holding RAM[a] = a.
    always @(posedge clk) begin
        if (rdEn) rdData <= rdAddr[7:0];
        if (gRdEn) gRdData <= gRdAddr[7:0];
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pushFrame();
        expPix_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.pix = 8'(a);
            e.sof = (a == 0);
            e.eol = ((a % WIDTH) == WIDTH - 1);
            e.eof = (a == NPIX - 1);
            expQ.push_back(e);
            gapQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start = v.start;
        hold  = v.hold;
    endtask

    task automatic checkOutput(input vec_t v, input int c);
        check($sformatf("c%0d_rd_en", c), 64'(rdEn), 64'(v.rdEn));
        check($sformatf("c%0d_valid", c), 64'(valid), 64'(v.valid));
        check($sformatf("c%0d_busy", c), 64'(busy), 64'(v.busy));
        check($sformatf("c%0d_done", c), 64'(done), 64'(v.done));
        if (v.rdEn) begin
            check($sformatf("c%0d_addr", c), 64'(rdAddr), 64'(v.addr));
            check($sformatf("c%0d_row", c), 64'(rowCnt), 64'(v.addr / WIDTH));
            check($sformatf("c%0d_col", c), 64'(colCnt), 64'(v.addr % WIDTH));
        end
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_ctl"}, 64'({rdEn, valid, sof, eol, eof, busy, done}), 64'd0);
        check({name, "_data"}, {rdAddr, pixel, rowCnt, colCnt}, 64'd0);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input int a, input logic v,
                                input logic b, input logic d);
        vec_t x;
        x.start = s; x.hold = 1'b0; x.rdEn = r; x.addr = a; x.valid = v; x.busy = b; x.done = d;
        return x;
    endfunction

    // Scoreboards: every valid pixel must be the next expected one, markers idle otherwise.
    always @(negedge clk) begin
        if (rstN) begin
            if (valid) begin
                if (expQ.size() == 0) begin
                    check("main_unexpected_valid", 64'(pixel), 64'hFFFF);
                end else begin
                    eMain = expQ.pop_front();
                    check("main_pixel", {pixel, sof, eol, eof}, {eMain.pix, eMain.sof, eMain.eol, eMain.eof});
                end
            end else begin
                check("main_idle_markers", 64'({sof, eol, eof}), 64'd0);
            end
            if (done) doneCount++;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            if (gValid) begin
                if (gapQ.size() == 0) begin
                    check("gap_unexpected_valid", 64'(gPixel), 64'hFFFF);
                end else begin
                    eGap = gapQ.pop_front();
                    check("gap_pixel", {gPixel, gSof, gEol, gEof}, {eGap.pix, eGap.sof, eGap.eol, eGap.eof});
                end
            end
            if (logGap && gRdEn) gapIssue.push_back(cyc);
            if (logGap && gDone) gapDoneCyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic found;

        rstN = 1'b0; start = 1'b0; hold = 1'b0;
        #1 checkAllZero("reset_state");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(posedge clk);

        // Frame 1: basic timing, plus a second start at cycle 5 that must be ignored.
        vecs[0]  = mk(1, 0, 0,  0, 0, 0);
        vecs[1]  = mk(0, 1, 0,  0, 1, 0);
        vecs[2]  = mk(0, 1, 1,  0, 1, 0);
        vecs[3]  = mk(0, 1, 2,  1, 1, 0);
        vecs[4]  = mk(0, 1, 3,  1, 1, 0);
        vecs[5]  = mk(1, 1, 4,  1, 1, 0);
        vecs[6]  = mk(0, 1, 5,  1, 1, 0);
        vecs[7]  = mk(0, 1, 6,  1, 1, 0);
        vecs[8]  = mk(0, 1, 7,  1, 1, 0);
        vecs[9]  = mk(0, 1, 8,  1, 1, 0);
        vecs[10] = mk(0, 1, 9,  1, 1, 0);
        vecs[11] = mk(0, 1, 10, 1, 1, 0);
        vecs[12] = mk(0, 1, 11, 1, 1, 0);
        vecs[13] = mk(0, 0, 0,  1, 1, 0);
        vecs[14] = mk(0, 0, 0,  1, 1, 0);
        vecs[15] = mk(0, 0, 0,  0, 1, 0);
        vecs[16] = mk(0, 0, 0,  0, 1, 0);
        vecs[17] = mk(0, 0, 0,  0, 0, 1);
        vecs[18] = mk(0, 0, 0,  0, 0, 0);

        pushFrame();
        doneCount = 0;
        logGap = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1 applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end
        for (int k = 0; k < 20 && gapDoneCyc < 0; k++) @(negedge clk);
        logGap = 1'b0;
        check("gap_done_seen", 64'(gapDoneCyc >= 0), 64'd1);
        check("gap_issue_count", 64'(gapIssue.size()), 64'(NPIX));
        if (gapIssue.size() == NPIX) begin
            for (int k = 1; k < NPIX; k++)
                check($sformatf("gap_spacing_%0d", k), 64'(gapIssue[k] - gapIssue[k-1]),
                      64'((k % WIDTH == 0) ? 3 : 1));
            check("gap_last_to_done", 64'(gapDoneCyc - gapIssue[NPIX-1]), 64'd5);
        end
        check("f1_done_count", 64'(doneCount), 64'd1);
        check("f1_queue_empty", 64'(expQ.size() + gapQ.size()), 64'd0);

        // Frame 2: hold for three cycles right after address 5 is issued.
        repeat (3) @(negedge clk);
        pushFrame();
        doneCount = 0;
        for (int c = 0; c < 23; c++) begin
            v.start = (c == 0);
            v.hold  = (c >= 6 && c <= 8);
            v.rdEn  = (c >= 1 && c <= 6) || (c >= 10 && c <= 15);
            v.addr  = (c <= 6) ? c - 1 : c - 4;
            v.valid = (c >= 3 && c <= 8) || (c >= 12 && c <= 17);
            v.busy  = (c >= 1 && c <= 19);
            v.done  = (c == 20);
            @(posedge clk);
            #1 applyStimulus(v);
            @(negedge clk);
            checkOutput(v, 100 + c);
        end
        repeat (5) @(negedge clk);
        check("f2_done_count", 64'(doneCount), 64'd1);
        check("f2_queue_empty", 64'(expQ.size() + gapQ.size()), 64'd0);

        // Frame 3: asynchronous reset while pixel 6 is on the output, then a clean restart.
        pushFrame();
        doneCount = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid && pixel == 8'd6) begin
                found = 1'b1;
                break;
            end
        end
        check("pixel6_seen", 64'(found), 64'd1);
        #2 rstN = 1'b0;
        expQ.delete();
        gapQ.delete();
        #1 checkAllZero("async_reset");
        @(negedge clk);
        checkAllZero("reset_held");
        @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        check("after_reset_busy", 64'(busy), 64'd0);
        check("after_reset_done_count", 64'(doneCount), 64'd0);

        pushFrame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("f3_done_seen", 64'(found), 64'd1);
        repeat (8) @(negedge clk);
        check("f3_done_count", 64'(doneCount), 64'd1);
        check("f3_queue_empty", 64'(expQ.size() + gapQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
